cv32e40p_register_file_ecc_scrubber: RTL and testbench

//  Background SECDED scrubber for the ECC-protected register file, parametrised in data width and depth.

---
 rtl/cv32e40p_register_file_ecc_scrubber.sv | 202 ++++++++++++++++++++
 tb/tb_cv32e40p_register_file_ecc_scrubber.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_register_file_ecc_scrubber.sv
// Background SECDED scrubber for the ECC register file: walks every word through the
// spare port, writes back corrected single-bit errors and flags double-bit errors.
module cv32e40p_register_file_ecc_scrubber #(
  parameter int DATA_WIDTH     = 32,
  parameter int PAR_WIDTH      = 6,
  parameter int NUM_WORDS      = 32,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int SKIP_ZERO      = 1,
  parameter int CNT_WIDTH      = 16,
  localparam int ADDR_WIDTH    = $clog2(NUM_WORDS),
  localparam int CW_WIDTH      = DATA_WIDTH + PAR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en_i,
  input  logic                  rf_busy_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_i,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic                  rd_gnt_i,
  input  logic [CW_WIDTH-1:0]   rd_rdata_i,
  output logic                  wr_req_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [CW_WIDTH-1:0]   wr_wdata_o,
  input  logic                  wr_gnt_i,
  output logic                  err_single_o,
  output logic                  err_double_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic                  busy_o
);

  localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [IW-1:0]         IV_LAST  = IW'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = (SKIP_ZERO != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(NUM_WORDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;

  // Hamming position p (1-based) lives in codeword bit p-1; parity at powers of two.
  function automatic logic [CW_WIDTH-1:0] ecc_enc(input logic [DATA_WIDTH-1:0] d);
    logic [CW_WIDTH-1:0] cw;
    logic                x;
    int                  j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < CW_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int i = 0; i < PAR_WIDTH; i++) begin
      x = 1'b0;
      for (int p = 1; p < CW_WIDTH; p++)
        if (((p >> i) & 1) != 0) x = x ^ cw[p-1];
      cw[(1 << i) - 1] = x;
    end
    cw[CW_WIDTH-1] = ^cw[CW_WIDTH-2:0];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ecc_data(input logic [CW_WIDTH-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int                    j;
    d = '0;
    j = 0;
    for (int p = 1; p < CW_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [PAR_WIDTH-1:0] ecc_syn(input logic [CW_WIDTH-1:0] cw);
    logic [PAR_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < PAR_WIDTH; i++)
      for (int p = 1; p < CW_WIDTH; p++)
        if (((p >> i) & 1) != 0) s[i] = s[i] ^ cw[p-1];
    return s;
  endfunction

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [IW-1:0]         ivl_cnt;
  logic [CW_WIDTH-1:0]   cw_q;
  logic                  cancel_q;
  logic                  conflict;
  logic [PAR_WIDTH-1:0]  syn;
  logic                  ov;
  logic                  is_single;
  logic                  is_double;
  logic [CW_WIDTH-1:0]   fixed;
  logic [CW_WIDTH-1:0]   reenc;

  // A core write to the word in flight makes our copy stale.
  assign conflict = core_we_i && (core_waddr_i == ptr) &&
                    ((state == S_CAPT) || (state == S_CHECK) || (state == S_WRITE));

  assign rd_req_o  = (state == S_READ) && !rf_busy_i;
  assign rd_addr_o = (state == S_READ) ? ptr : '0;
  assign wr_req_o  = (state == S_WRITE) && !rf_busy_i && !conflict;
  assign wr_addr_o = (state == S_WRITE) ? ptr : '0;
  assign busy_o    = (state != S_IDLE) && (state != S_WAIT);

  always_comb begin
    syn       = ecc_syn(cw_q);
    ov        = ^cw_q;
    is_single = 1'b0;
    is_double = 1'b0;
    fixed     = cw_q;
    if (ov) begin
      if (syn == '0) begin
        is_single = 1'b1;
      end else if (int'(syn) <= CW_WIDTH - 1) begin
        is_single = 1'b1;
        fixed     = cw_q ^ (CW_WIDTH'(1) << (syn - PAR_WIDTH'(1)));
      end else begin
        is_double = 1'b1;
      end
    end else if (syn != '0) begin
      is_double = 1'b1;
    end
  end

  assign reenc = ecc_enc(ecc_data(fixed));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= PTR_FIRST;
      ivl_cnt      <= '0;
      cw_q         <= '0;
      cancel_q     <= 1'b0;
      wr_wdata_o   <= '0;
      err_single_o <= 1'b0;
      err_double_o <= 1'b0;
      err_addr_o   <= '0;
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else begin
      err_single_o <= 1'b0;
      err_double_o <= 1'b0;
      case (state)
        S_IDLE: if (scrub_en_i) state <= S_WAIT;
        S_WAIT: begin
          if (!scrub_en_i) begin
            state   <= S_IDLE;
            ivl_cnt <= '0;
          end else if (ivl_cnt == IV_LAST) begin
            state   <= S_READ;
            ivl_cnt <= '0;
          end else begin
            ivl_cnt <= ivl_cnt + IW'(1);
          end
        end
        S_READ: begin
          cancel_q <= 1'b0;
          if (rd_req_o && rd_gnt_i) state <= S_CAPT;
        end
        S_CAPT: begin
          cw_q  <= rd_rdata_i;
          state <= S_CHECK;
          if (conflict) cancel_q <= 1'b1;
        end
        S_CHECK: begin
          state <= S_NEXT;
          if (is_single) begin
            err_single_o <= 1'b1;
            err_addr_o   <= ptr;
            wr_wdata_o   <= reenc;
            if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + CNT_WIDTH'(1);
            // Counted regardless; only the write-back is skipped on a conflict.
            if (!cancel_q && !conflict) state <= S_WRITE;
          end else if (is_double) begin
            err_double_o <= 1'b1;
            err_addr_o   <= ptr;
            if (uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + CNT_WIDTH'(1);
          end
        end
        S_WRITE: if (conflict || (wr_req_o && wr_gnt_i)) state <= S_NEXT;
        S_NEXT: begin
          ptr   <= (ptr == PTR_LAST) ? PTR_FIRST : ptr + ADDR_WIDTH'(1);
          state <= scrub_en_i ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_register_file_ecc_scrubber.sv
// Scoreboard bench: dut drives a 32-word memory model with planted faults; dut2 (4 words)
// checks the address walk and reset behaviour.
module tb_cv32e40p_register_file_ecc_scrubber;

  typedef struct {
    logic        dbl;
    logic [4:0]  addr;
    logic        wr;
    logic [38:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic        x;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 39; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    for (int i = 0; i < 6; i++) begin
      x = 1'b0;
      for (int p = 1; p < 39; p++)
        if (((p >> i) & 1) != 0) x = x ^ cw[p-1];
      cw[(1 << i) - 1] = x;
    end
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  function automatic logic [31:0] dat(input int a);
    return 32'hDEADBEEF + 32'(a) * 32'h00010001 - 32'h00070007;
  endfunction

  // ---------------- main DUT (32 words) ----------------
  logic        rst_n, scrub_en, rf_busy, core_we;
  logic [4:0]  core_waddr;
  logic [38:0] core_wdata;
  logic        rd_req, rd_gnt, wr_req, wr_gnt;
  logic [4:0]  rd_addr, wr_addr, err_addr;
  logic [38:0] rd_rdata, wr_wdata;
  logic        err_single, err_double, busy;
  logic [15:0] corr_cnt, uncorr_cnt;

  cv32e40p_register_file_ecc_scrubber #(.SCRUB_INTERVAL(4)) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en_i(scrub_en), .rf_busy_i(rf_busy),
    .core_we_i(core_we), .core_waddr_i(core_waddr),
    .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_gnt_i(rd_gnt), .rd_rdata_i(rd_rdata),
    .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_wdata_o(wr_wdata), .wr_gnt_i(wr_gnt),
    .err_single_o(err_single), .err_double_o(err_double), .err_addr_o(err_addr),
    .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt), .busy_o(busy)
  );

  assign rd_gnt = rd_req;
  assign wr_gnt = wr_req;

  logic [38:0] mem [32];
  logic        wr_hs;
  logic [4:0]  wr_hs_addr;
  logic [38:0] wr_hs_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= enc(dat(i));
      rd_rdata <= '0;
      wr_hs    <= 1'b0;
    end else begin
      if (rd_req && rd_gnt) rd_rdata <= mem[rd_addr];
      wr_hs      <= wr_req && wr_gnt;
      wr_hs_addr <= wr_addr;
      wr_hs_data <= wr_wdata;
      if (wr_req && wr_gnt) mem[wr_addr] <= wr_wdata;
      if (core_we) mem[core_waddr] <= core_wdata;
    end
  end

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        pend = 1'b0;
  logic [4:0]  pend_addr;
  logic [38:0] pend_data;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_excl", rd_req & wr_req, 1'b0);
      if (err_single || err_double) begin
        if (exp_q.size() == 0) chk("unexp_err", {err_single, err_double}, 2'b00);
        else begin
          mon_e = exp_q.pop_front();
          chk("err_kind", {err_single, err_double}, mon_e.dbl ? 2'b01 : 2'b10);
          chk("err_addr", err_addr, mon_e.addr);
          if (mon_e.wr) begin
            chk("wdata", wr_wdata, mon_e.wdata);
            pend      = 1'b1;
            pend_addr = mon_e.addr;
            pend_data = mon_e.wdata;
          end
        end
      end
      if (wr_hs) begin
        if (!pend) chk("unexp_wr", wr_hs, 1'b0);
        else begin
          chk("wr_addr", wr_hs_addr, pend_addr);
          chk("wr_data", wr_hs_data, pend_data);
          pend = 1'b0;
        end
      end
    end
  end

  // ---------------- small DUT (4 words, interval 1) ----------------
  logic        rst2_n, en2, rf_busy2, rd_req2, wr_req2, err_single2, err_double2, busy2;
  logic [1:0]  rd_addr2, wr_addr2, err_addr2;
  logic [38:0] wr_wdata2;
  logic [38:0] zero_cw = '0;
  logic [1:0]  zero_a = '0;
  logic        zero_b = 1'b0;
  logic [15:0] corr_cnt2, uncorr_cnt2;

  cv32e40p_register_file_ecc_scrubber #(.NUM_WORDS(4), .SCRUB_INTERVAL(1), .SKIP_ZERO(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .scrub_en_i(en2), .rf_busy_i(rf_busy2),
    .core_we_i(zero_b), .core_waddr_i(zero_a),
    .rd_req_o(rd_req2), .rd_addr_o(rd_addr2), .rd_gnt_i(rd_req2), .rd_rdata_i(zero_cw),
    .wr_req_o(wr_req2), .wr_addr_o(wr_addr2), .wr_wdata_o(wr_wdata2), .wr_gnt_i(wr_req2),
    .err_single_o(err_single2), .err_double_o(err_double2), .err_addr_o(err_addr2),
    .corr_cnt_o(corr_cnt2), .uncorr_cnt_o(uncorr_cnt2), .busy_o(busy2)
  );

  logic       rd_hs2 = 1'b0;
  logic [1:0] rd_hs2_addr;
  logic [1:0] addr2_q[$];
  logic [1:0] mon2_a;

  always @(posedge clk) begin
    rd_hs2      <= rd_req2;
    rd_hs2_addr <= rd_addr2;
  end

  always @(negedge clk) begin
    if (rst2_n && rd_hs2 && addr2_q.size() != 0) begin
      mon2_a = addr2_q.pop_front();
      chk("t6_addr", rd_hs2_addr, mon2_a);
    end
  end

  task automatic plant(input logic [4:0] a, input logic [38:0] cw);
    @(negedge clk);
    core_we = 1'b1; core_waddr = a; core_wdata = cw;
    @(negedge clk);
    core_we = 1'b0;
  endtask

  task automatic push_err(input logic dbl, input logic [4:0] a, input logic wr, input logic [38:0] w);
    exp_t e;
    e.dbl = dbl; e.addr = a; e.wr = wr; e.wdata = w;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; scrub_en = 1'b0; rf_busy = 1'b0;
    core_we = 1'b0; core_waddr = '0; core_wdata = '0; en2 = 1'b0; rf_busy2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {rd_req, wr_req, busy, err_single, err_double}, 5'b0);
    chk("rst_addr", {rd_addr, wr_addr, err_addr}, 15'b0);
    chk("rst_wdata", wr_wdata, 39'b0);
    chk("rst_cnt", {corr_cnt, uncorr_cnt}, 32'b0);
    rst_n = 1'b1; rst2_n = 1'b1;

    // Address walk with x0 skipped and wrap at NUM_WORDS-1.
    addr2_q = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    en2 = 1'b1;
    for (int n = 0; n < 300 && addr2_q.size() != 0; n++) @(negedge clk);
    chk("t6_seq_left", addr2_q.size(), 0);
    rf_busy2 = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_stall_busy", busy2, 1'b1);
    chk("t6_stall_req", rd_req2, 1'b0);
    rst2_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_out", {rd_req2, rd_addr2, wr_req2, wr_addr2, err_single2, err_double2, err_addr2, busy2}, 11'b0);
    chk("t6_rst_cnt", {corr_cnt2, uncorr_cnt2, wr_wdata2}, 71'b0);
    rst2_n = 1'b1; rf_busy2 = 1'b0;
    addr2_q = '{2'd1, 2'd2};
    for (int n = 0; n < 300 && addr2_q.size() != 0; n++) @(negedge clk);
    chk("t6_post_rst_left", addr2_q.size(), 0);
    en2 = 1'b0;

    // Pass 1: double at 3 (data bits 0,9), single at 7 (data bit 5), overall-parity flip at 12.
    plant(5'd3, enc(dat(3)) ^ (39'd1 << 2) ^ (39'd1 << 13));
    plant(5'd7, enc(dat(7)) ^ (39'd1 << 9));
    plant(5'd12, enc(dat(12)) ^ (39'd1 << 38));
    push_err(1'b1, 5'd3, 1'b0, '0);
    push_err(1'b0, 5'd7, 1'b1, enc(32'hDEADBEEF));
    push_err(1'b0, 5'd12, 1'b1, enc(dat(12)));
    scrub_en = 1'b1;
    for (int n = 0; n < 3000 && !(exp_q.size() == 0 && !pend); n++) @(negedge clk);
    chk("p1_left", exp_q.size() + int'(pend), 0);
    scrub_en = 1'b0;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("p1_idle", busy, 1'b0);
    chk("p1_corr", corr_cnt, 16'd2);
    chk("p1_uncorr", uncorr_cnt, 16'd1);
    chk("p1_mem7", mem[7], enc(32'hDEADBEEF));
    chk("p1_mem12", mem[12], enc(dat(12)));
    chk("p1_mem3", mem[3], enc(dat(3)) ^ (39'd1 << 2) ^ (39'd1 << 13));

    // Pass 2: core overwrites addr 7 while its write-back is pending.
    plant(5'd3, enc(dat(3)));
    plant(5'd7, enc(dat(7)) ^ (39'd1 << 9));
    push_err(1'b0, 5'd7, 1'b0, '0);
    scrub_en = 1'b1;
    for (int n = 0; n < 3000 && !(err_single && err_addr == 5'd7); n++) @(negedge clk);
    chk("t5_pulse", err_single, 1'b1);
    chk("t5_wr_pre", wr_req, 1'b1);
    rf_busy = 1'b1; core_we = 1'b1; core_waddr = 5'd7; core_wdata = enc(32'h12345678);
    #1;
    chk("t5_wr_drop", wr_req, 1'b0);
    @(posedge clk);
    #1;
    core_we = 1'b0;
    chk("t5_corr", corr_cnt, 16'd3);
    repeat (3) @(negedge clk);
    rf_busy = 1'b0;
    for (int n = 0; n < 200 && !rd_req; n++) @(negedge clk);
    chk("t5_next_addr", rd_addr, 5'd8);
    chk("t5_mem7", mem[7], enc(32'h12345678));
    scrub_en = 1'b0;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("end_idle", busy, 1'b0);
    chk("end_sb", exp_q.size() + int'(pend), 0);
    chk("end_uncorr", uncorr_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
